bmp_loader: RTL and testbench
=============================

# bmp_loader

Fetch engine that sits directly upstream of the bitmap register in the compare/accumulate path. On `start` it reads 64 consecutive 24-bit rows from a synchronous row memory and packs them into a 1536-bit bitmap bus. It then pulses `wren` for one cycle, which both loads the bitmap register and kicks the compare ALU.

## Interface
- `ROWS`, default 64: rows per bitmap.
- `ROW_W`, default 24: bits per row.
- `ADDR_W`, default 16: row-memory address width.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  load request; sampled only in IDLE.
- `base_addr`  in  ADDR_W  address of row 0; latched when `start` is accepted.
- `mem_addr`  out  ADDR_W  row-memory read address.
- `mem_rd`  out  1  row-memory read strobe.
- `mem_data`  in  ROW_W  read data; valid exactly one cycle after the `mem_rd` cycle.
- `bitmap`  out  ROWS*ROW_W  packed bitmap; row r occupies `bitmap[r*ROW_W +: ROW_W]`, so row 0 is in the LSBs.
- `wren`  out  1  one-cycle pulse meaning `bitmap` is complete; drives the bitmap register's write enable.
- `busy`  out  1  high from start acceptance through the `wren` cycle.

## Operation
- States:
  - IDLE: `start`=1 → ISSUE; latch `base_addr`; clear row and issue counters.
  - ISSUE: assert `mem_rd` with `mem_addr` = base + issue count, then increment the issue count. After the ROWS-th issue → DRAIN.
  - DRAIN: capture the last row of data → PULSE.
  - PULSE: assert `wren` → IDLE.
- Capture rule: every cycle whose previous cycle had `mem_rd`=1 writes `mem_data` into the slot for the current row count, then increments the row count. This rule applies in both ISSUE and DRAIN.
- Address arithmetic is modulo 2^ADDR_W. Base 0xFFF0 reads 0xFFF0..0x002F with wrap and no error.
- `start` outside IDLE is ignored and is not queued, including in the PULSE cycle.
- `bitmap` holds its value between loads.
  - During a load, rows are overwritten progressively.
  - Consumers must sample `bitmap` only on `wren`.
- `rst` asserted at any time, including mid-load:
  - state returns to IDLE immediately;
  - `mem_rd`, `wren` and `busy` go to 0;
  - `bitmap` is cleared to 0 and counters go to 0;
  - no `wren` is produced for the aborted load.
- Reset values: `mem_addr`=0, `mem_rd`=0, `bitmap`=0, `wren`=0, `busy`=0.

## Timing
- `start` is accepted at edge T0. In the cycles after T0:
  - Cycles 1..64: `mem_rd`=1, `mem_addr`=base+0 .. base+63.
  - Cycles 2..65: rows 0..63 are captured at the end of each cycle.
  - Cycle 66: `wren`=1 and `bitmap` is complete and stable. The downstream register captures it at the edge ending cycle 66.
  - Cycle 67: IDLE. `busy`=0 and a new `start` can be accepted.
- Latency from `start` to `wren` is ROWS+2 cycles. The minimum start-to-start period is ROWS+3 cycles.
- `wren` is exactly one cycle wide and never high in two consecutive cycles.
- `mem_rd` is registered and is never asserted outside ISSUE.

## Configuration
- `BMP_LOADER_INVERT_EN`:
  - When defined, each captured row is stored bitwise-inverted (`~mem_data`). This supports memories that store ink as 0.
  - When undefined, rows are stored unmodified.
- Timing, handshakes and reset behaviour are identical in both builds.

## Test plan
- Reset then idle: hold `rst` 3 cycles with `start`=0. All outputs stay 0 and `mem_rd` is never asserted.
- Basic load, memory row k = {8'hA5, k[15:0]}, base 0x0100, `start` at T0:
  - `mem_rd` is asserted at T0+1..T0+64 with addresses 0x0100..0x013F;
  - `wren` is high only at T0+66;
  - `bitmap[23:0]`=0xA50000 and `bitmap[1535:1512]`=0xA5003F.
- Wrap: base 0xFFE0. Addresses run 0xFFE0..0xFFFF then 0x0000..0x001F, and row 32 holds memory word 0x0000.
- Start while busy: pulse `start` at T0+10 and again at T0+66. Exactly one `wren` occurs (at T0+66), with no second load, and the next `start` at T0+67 is accepted.
- Reset mid-load: assert `rst` at T0+30.
  - `mem_rd`, `busy` and `bitmap` go to 0 without waiting for a clock edge.
  - No `wren` appears in the following 100 cycles.
  - A subsequent `start` completes normally.
- With `BMP_LOADER_INVERT_EN` defined, all memory rows = 24'h00FF00. Every row of `bitmap` = 24'hFF00FF, and `wren` still falls at T0+66.

Source files
------------

// File: rtl/bmp_loader.sv
// bmp_loader: on start, reads ROWS consecutive ROW_W-bit rows from a synchronous
// row memory (one-cycle read latency) and packs them into a ROWS*ROW_W bitmap,
// then pulses wren for one cycle to load the downstream bitmap register.
// Ports: clk/rst (async active-high); start + base_addr request a load (IDLE only);
// mem_addr/mem_rd/mem_data form the row-memory read port; bitmap is the packed
// result (row 0 in LSBs); wren marks bitmap complete; busy spans start..wren.
// Optional build macro BMP_LOADER_INVERT_EN: store each captured row as ~mem_data.
module bmp_loader #(
  parameter int ROWS   = 64,
  parameter int ROW_W  = 24,
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_rd,
  input  logic [ROW_W-1:0]      mem_data,
  output logic [ROWS*ROW_W-1:0] bitmap,
  output logic                  wren,
  output logic                  busy
);

  localparam int CNT_W = $clog2(ROWS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    PULSE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]      row_cnt_q, row_cnt_d;
  logic                  mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic                  rd_prev_q, rd_prev_d;
  logic [ROWS*ROW_W-1:0] bitmap_q, bitmap_d;
  logic [ROW_W-1:0]      row_data;

`ifdef BMP_LOADER_INVERT_EN
  // Memories that store ink as 0 are normalised here so the bitmap is ink-as-1.
  assign row_data = ~mem_data;
`else
  assign row_data = mem_data;
`endif

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    row_cnt_d   = row_cnt_q;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    bitmap_d    = bitmap_q;
    // Read data returns one cycle after the strobe, so capture keys off the
    // delayed strobe rather than the state; this covers both ISSUE and DRAIN.
    rd_prev_d   = mem_rd_q;

    if (rd_prev_q) begin
      for (int r = 0; r < ROWS; r++) begin
        if (row_cnt_q == CNT_W'(r)) begin
          bitmap_d[r*ROW_W +: ROW_W] = row_data;
        end
      end
      row_cnt_d = row_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // The first read is issued straight from IDLE so mem_rd is high in the
          // very next cycle; issue_cnt therefore starts at one.
          base_d      = base_addr;
          row_cnt_d   = '0;
          issue_cnt_d = CNT_W'(1);
          mem_rd_d    = 1'b1;
          mem_addr_d  = base_addr;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_cnt_q == CNT_W'(ROWS)) begin
          state_d = DRAIN;
        end else begin
          // Wraps modulo 2^ADDR_W by truncation.
          mem_addr_d  = base_q + ADDR_W'(issue_cnt_q);
          mem_rd_d    = 1'b1;
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        // The last row lands this cycle via the capture rule above.
        state_d = PULSE;
      end
      PULSE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      row_cnt_q   <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      rd_prev_q   <= 1'b0;
      bitmap_q    <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      row_cnt_q   <= row_cnt_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      rd_prev_q   <= rd_prev_d;
      bitmap_q    <= bitmap_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign bitmap   = bitmap_q;
  assign wren     = (state_q == PULSE);
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_bmp_loader.sv
// tb_bmp_loader: drives bmp_loader against a synchronous row-memory model.
// Expected read addresses and bitmap rows are queued when a load is started and
// popped as the DUT issues reads and pulses wren; timing is checked per load.
module tb_bmp_loader;

  localparam int ROWS   = 64;
  localparam int ROW_W  = 24;
  localparam int ADDR_W = 16;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [ADDR_W-1:0]     base_addr;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_rd;
  logic [ROW_W-1:0]      mem_data;
  logic [ROWS*ROW_W-1:0] bitmap;
  logic                  wren;
  logic                  busy;

  bmp_loader #(.ROWS(ROWS), .ROW_W(ROW_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .bitmap(bitmap), .wren(wren), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int wren_cnt = 0;
  int wren_base = 0;
  int last_wren_cyc = -1;
  int first_rd_cyc = -1;
  int last_rd_cyc = -1;
  int rd_cnt = 0;
  logic prev_wren = 1'b0;
  logic [15:0] mem_off = '0;
  logic        mem_mode = 1'b0;

  logic [ADDR_W-1:0] addr_q[$];
  logic [ROW_W-1:0]  row_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: mode 0 is {A5, address - offset}; mode 1 is a constant.
  function automatic logic [ROW_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [15:0] k;
    k = a - mem_off;
    return mem_mode ? 24'h00FF00 : {8'hA5, k};
  endfunction

  function automatic logic [ROW_W-1:0] stored(input logic [ROW_W-1:0] w);
`ifdef BMP_LOADER_INVERT_EN
    return ~w;
`else
    return w;
`endif
  endfunction

  // Synchronous memory: data valid the cycle after the read strobe, junk otherwise.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem_word(mem_addr);
    else        mem_data <= 24'h5A5A5A;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd) begin
        rd_cnt++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        last_rd_cyc = cyc;
        if (addr_q.size() == 0) chk("unexpected_rd", 1, 0);
        else chk("mem_addr", mem_addr, addr_q.pop_front());
      end
      if (wren) begin
        wren_cnt++;
        last_wren_cyc = cyc;
        chk("busy_at_wren", busy, 1);
        chk("wren_consecutive", prev_wren, 0);
        for (int r = 0; r < ROWS; r++) begin
          if (row_q.size() == 0) chk("row_q_empty", 1, 0);
          else chk("bitmap_row", bitmap[r*ROW_W +: ROW_W], row_q.pop_front());
        end
      end
      prev_wren = wren;
    end else begin
      prev_wren = 1'b0;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called mid-cycle; returns in cycle 1 of the load (just after edge T0).
  task automatic start_load(input logic [ADDR_W-1:0] b);
    start = 1'b1;
    base_addr = b;
    for (int k = 0; k < ROWS; k++) begin
      logic [ADDR_W-1:0] a;
      a = b + ADDR_W'(k);
      addr_q.push_back(a);
      row_q.push_back(stored(mem_word(a)));
    end
    first_rd_cyc = -1;
    rd_cnt = 0;
    wren_base = wren_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc - 1;
  endtask

  // From cycle 1 of a load, advances to cycle 67 and checks the load's timing.
  task automatic finish_load();
    wait_cycles(66);
    chk("wren_count", wren_cnt, wren_base + 1);
    chk("wren_cycle", last_wren_cyc - t0, 66);
    chk("first_rd_cycle", first_rd_cyc - t0, 1);
    chk("last_rd_cycle", last_rd_cyc - t0, 64);
    chk("rd_count", rd_cnt, ROWS);
    chk("busy_after", busy, 0);
    chk("addr_q_left", addr_q.size(), 0);
    chk("row_q_left", row_q.size(), 0);
  endtask

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [15:0]       off;
    logic              mode;
    logic [ROW_W-1:0]  row0;
    logic [ROW_W-1:0]  row32;
    logic [ROW_W-1:0]  row63;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{base: 16'h0100, off: 16'h0100, mode: 1'b0,
                row0: 24'hA50000, row32: 24'hA50020, row63: 24'hA5003F};
    vecs[1] = '{base: 16'hFFE0, off: 16'h0000, mode: 1'b0,
                row0: 24'hA5FFE0, row32: 24'hA50000, row63: 24'hA5001F};
    vecs[2] = '{base: 16'hFFF0, off: 16'h0000, mode: 1'b0,
                row0: 24'hA5FFF0, row32: 24'hA50010, row63: 24'hA5002F};
    vecs[3] = '{base: 16'h1234, off: 16'h0000, mode: 1'b1,
                row0: 24'h00FF00, row32: 24'h00FF00, row63: 24'h00FF00};

    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;

    // Reset held for three cycles: every output stays at zero.
    repeat (3) begin
      @(negedge clk);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_wren", wren, 0);
      chk("rst_busy", busy, 0);
      chk("rst_bitmap_zero", (bitmap == '0), 1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cycles(3);
    chk("idle_no_wren", wren_cnt, 0);

    // Table of full loads.
    for (int i = 0; i < 4; i++) begin
      mem_off = vecs[i].off;
      mem_mode = vecs[i].mode;
      start_load(vecs[i].base);
      finish_load();
      chk("tbl_row0", bitmap[0 +: ROW_W], stored(vecs[i].row0));
      chk("tbl_row32", bitmap[32*ROW_W +: ROW_W], stored(vecs[i].row32));
      chk("tbl_row63", bitmap[63*ROW_W +: ROW_W], stored(vecs[i].row63));
    end

    // Start while busy: ignored at T0+10 and in the PULSE cycle; next start at T0+67.
    mem_off = 16'h0200;
    mem_mode = 1'b0;
    start_load(16'h0200);
    wait_cycles(9);
    start = 1'b1;
    base_addr = 16'h5555;
    wait_cycles(1);
    start = 1'b0;
    chk("busy_mid_load", busy, 1);
    wait_cycles(55);
    chk("wren_cycle66", wren, 1);
    start = 1'b1;
    base_addr = 16'h7777;
    wait_cycles(1);
    chk("busy_cycle67", busy, 0);
    chk("wren_cycle67", wren, 0);
    chk("single_wren", wren_cnt, wren_base + 1);
    chk("busy_wren_cycle", last_wren_cyc - t0, 66);
    mem_off = 16'h0300;
    start_load(16'h0300);
    finish_load();
    chk("b2b_row63", bitmap[63*ROW_W +: ROW_W], stored(24'hA5003F));

    // Reset in the middle of a load.
    mem_off = 16'h0000;
    start_load(16'h4000);
    wait_cycles(29);
    chk("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_mem_rd", mem_rd, 0);
    chk("arst_busy", busy, 0);
    chk("arst_wren", wren, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_bitmap_zero", (bitmap == '0), 1);
    addr_q.delete();
    row_q.delete();
    wren_base = wren_cnt;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(100);
    chk("no_wren_after_abort", wren_cnt, wren_base);
    mem_off = 16'h0100;
    start_load(16'h0100);
    finish_load();
    chk("post_rst_row0", bitmap[0 +: ROW_W], stored(24'hA50000));
    chk("post_rst_row63", bitmap[63*ROW_W +: ROW_W], stored(24'hA5003F));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
